// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit for the 5-stage core. It keeps an in-order FIFO of
// destination registers for loads still waiting on a variable-latency memory.
module load_use_scoreboard #(
  parameter int REG_IDX_W = 5,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [6:0]                 id_opcode,
  input  logic [REG_IDX_W-1:0]       id_rs1_idx,
  input  logic [REG_IDX_W-1:0]       id_rs2_idx,
  input  logic                       ex_valid,
  input  logic                       ex_mem_read,
  input  logic [REG_IDX_W-1:0]       ex_rd_idx,
  input  logic                       ex_flush,
  input  logic                       mem_resp_valid,
  input  logic                       cnt_clr,
  output logic                       load_use_stall,
  output logic                       sb_full,
  output logic [$clog2(DEPTH+1)-1:0] sb_count,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]    FULL_C  = CW'(DEPTH);
  localparam logic [PW-1:0]    LAST_C  = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;

  logic [REG_IDX_W-1:0] entry_q [DEPTH];
  logic [REG_IDX_W-1:0] entry_d [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CNT_W-1:0]     cycles_q, cycles_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;

  logic has_rs1, has_rs2, alloc, pop, push, hit1, hit2;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Push (alloc) and pop (response) are single-cycle strobes with no
  // back-pressure: alloc is accepted unless full without a same-cycle pop,
  // and a response only retires an entry when one is outstanding.
  assign alloc   = ex_valid & ex_mem_read & ~ex_flush & (ex_rd_idx != '0);
  assign pop     = mem_resp_valid & (count_q != '0);
  assign sb_full = (count_q == FULL_C);
  assign push    = alloc & (~sb_full | pop);

  always_comb begin
    has_rs1 = 1'b1;
    case (id_opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM: has_rs1 = 1'b0;
      default: has_rs1 = 1'b1;
    endcase
    has_rs2 = (id_opcode == OP_R) || (id_opcode == OP_S) || (id_opcode == OP_B);
  end

  // The ex term covers the alloc cycle, before the entry is registered.
  always_comb begin
    hit1 = alloc && (id_rs1_idx == ex_rd_idx);
    hit2 = alloc && (id_rs2_idx == ex_rd_idx);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i] == id_rs1_idx)) hit1 = 1'b1;
      if (valid_q[i] && (entry_q[i] == id_rs2_idx)) hit2 = 1'b1;
    end
    hit1 = hit1 && (id_rs1_idx != '0);
    hit2 = hit2 && (id_rs2_idx != '0);
  end

  assign load_use_stall = rst_n & id_valid & ((has_rs1 & hit1) | (has_rs2 & hit2));

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Pop before push so a full-with-pop alloc reuses the freed slot.
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      entry_d[tail_q] = ex_rd_idx;
      tail_d          = ptr_inc(tail_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (alloc & sb_full & ~pop);
    unf_d = unf_q | (mem_resp_valid & (count_q == '0));
    if (cnt_clr)
      cycles_d = '0;
    else if (load_use_stall && (cycles_q != CNT_MAX))
      cycles_d = cycles_q + 1'b1;
    else
      cycles_d = cycles_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      valid_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      entry_q  <= entry_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      cycles_q <= cycles_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign sb_count      = count_q;
  assign stall_cycles  = cycles_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard: the driver queues hand-computed
// expectations each cycle and a negedge monitor compares them against outputs.
module tb_load_use_scoreboard;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  localparam logic [2:0] F_STALL = 3'd0;
  localparam logic [2:0] F_FULL  = 3'd1;
  localparam logic [2:0] F_COUNT = 3'd2;
  localparam logic [2:0] F_CYC   = 3'd3;
  localparam logic [2:0] F_OVF   = 3'd4;
  localparam logic [2:0] F_UNF   = 3'd5;
  localparam logic [2:0] F_SAT   = 3'd6;

  logic clk, rst_n;
  logic id_valid, ex_valid, ex_mem_read, ex_flush, mem_resp_valid, cnt_clr;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1_idx, id_rs2_idx, ex_rd_idx;
  logic load_use_stall, sb_full, err_overflow, err_underflow;
  logic [2:0] sb_count;
  logic [15:0] stall_cycles;
  logic s_stall, s_full, s_ovf, s_unf;
  logic [1:0] s_count, s_cycles;

  logic [18:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;

  load_use_scoreboard #(.REG_IDX_W(5), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd_idx(ex_rd_idx), .ex_flush(ex_flush),
    .mem_resp_valid(mem_resp_valid), .cnt_clr(cnt_clr),
    .load_use_stall(load_use_stall), .sb_full(sb_full), .sb_count(sb_count),
    .stall_cycles(stall_cycles), .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  // Narrow-counter, odd-depth instance used for saturation checks.
  load_use_scoreboard #(.REG_IDX_W(5), .DEPTH(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd_idx(ex_rd_idx), .ex_flush(ex_flush),
    .mem_resp_valid(mem_resp_valid), .cnt_clr(cnt_clr),
    .load_use_stall(s_stall), .sb_full(s_full), .sb_count(s_count),
    .stall_cycles(s_cycles), .err_overflow(s_ovf), .err_underflow(s_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    id_valid = 0; id_opcode = '0; id_rs1_idx = '0; id_rs2_idx = '0;
    ex_valid = 0; ex_mem_read = 0; ex_rd_idx = '0; ex_flush = 0;
    mem_resp_valid = 0; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_id(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2);
    id_valid = 1; id_opcode = op; id_rs1_idx = r1; id_rs2_idx = r2;
  endtask

  task automatic set_ex(input logic [4:0] rd, input logic fl);
    ex_valid = 1; ex_mem_read = 1; ex_rd_idx = rd; ex_flush = fl;
  endtask

  task automatic expect_f(input logic [2:0] sel, input int v);
    exp_q.push_back({sel, 16'(v)});
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [18:0] e;
      logic [15:0] act;
      string nm;
      e = exp_q.pop_front();
      case (e[18:16])
        F_STALL: begin act = 16'(load_use_stall); nm = "load_use_stall"; end
        F_FULL:  begin act = 16'(sb_full);        nm = "sb_full"; end
        F_COUNT: begin act = 16'(sb_count);       nm = "sb_count"; end
        F_CYC:   begin act = stall_cycles;        nm = "stall_cycles"; end
        F_OVF:   begin act = 16'(err_overflow);   nm = "err_overflow"; end
        F_UNF:   begin act = 16'(err_underflow);  nm = "err_underflow"; end
        default: begin act = 16'(s_cycles);       nm = "sat_stall_cycles"; end
      endcase
      n_chk++;
      if (act === e[15:0]) n_pass++;
      else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, e[15:0]);
    end
  end

  initial begin
    idle();
    rst_n = 0;
    #1;
    // Reset: stall gated off even with a live hazard on the inputs.
    set_id(OP_ADD, 5, 7); set_ex(5, 0);
    expect_f(F_STALL, 0);
    tick();
    rst_n = 1;
    expect_f(F_COUNT, 0); expect_f(F_FULL, 0); expect_f(F_CYC, 0);
    expect_f(F_OVF, 0); expect_f(F_UNF, 0); expect_f(F_STALL, 0); expect_f(F_SAT, 0);
    tick();

    // Back-to-back: load x5, ADD x6,x5,x7, response 3 cycles later.
    set_ex(5, 0); set_id(OP_ADD, 5, 7); expect_f(F_STALL, 1); expect_f(F_COUNT, 0); tick();
    set_id(OP_ADD, 5, 7); expect_f(F_STALL, 1); expect_f(F_COUNT, 1); tick();
    set_id(OP_ADD, 5, 7); expect_f(F_STALL, 1); tick();
    set_id(OP_ADD, 5, 7); mem_resp_valid = 1; expect_f(F_STALL, 1); expect_f(F_COUNT, 1); tick();
    set_id(OP_ADD, 5, 7); expect_f(F_STALL, 0); expect_f(F_COUNT, 0);
    expect_f(F_CYC, 4); expect_f(F_SAT, 3); tick();

    // Non-users of rs1/rs2 fields, SW via rs1, x0 loads.
    set_ex(5, 0); set_id(OP_LUI, 5, 5); expect_f(F_STALL, 0); tick();
    set_id(OP_JAL, 5, 5); expect_f(F_STALL, 0); expect_f(F_COUNT, 1); tick();
    set_id(OP_SW, 5, 8); expect_f(F_STALL, 1); tick();
    set_id(OP_ADDI, 1, 5); mem_resp_valid = 1; expect_f(F_STALL, 0); tick();
    set_ex(0, 0); set_id(OP_ADD, 0, 0); expect_f(F_STALL, 0); expect_f(F_COUNT, 0); tick();
    set_id(OP_ADDI, 5, 0); expect_f(F_STALL, 0); expect_f(F_COUNT, 0);
    expect_f(F_CYC, 5); expect_f(F_SAT, 3); tick();

    // Fill to DEPTH, drop on overflow, full alloc with pop.
    for (int i = 1; i <= 4; i++) begin
      set_ex(5'(i), 0); expect_f(F_COUNT, i - 1); tick();
    end
    set_ex(6, 0); set_id(OP_ADD, 6, 6);
    expect_f(F_COUNT, 4); expect_f(F_FULL, 1); expect_f(F_OVF, 0); expect_f(F_STALL, 1); tick();
    set_id(OP_ADD, 6, 6); expect_f(F_OVF, 1); expect_f(F_COUNT, 4); expect_f(F_STALL, 0); tick();
    set_ex(7, 0); mem_resp_valid = 1; set_id(OP_ADD, 1, 0);
    expect_f(F_STALL, 1); expect_f(F_FULL, 1); tick();
    set_id(OP_ADD, 1, 0); expect_f(F_COUNT, 4); expect_f(F_FULL, 1); expect_f(F_STALL, 0); tick();
    set_id(OP_ADD, 7, 0); mem_resp_valid = 1; expect_f(F_STALL, 1); tick();
    mem_resp_valid = 1; expect_f(F_COUNT, 3); expect_f(F_FULL, 0); tick();
    mem_resp_valid = 1; expect_f(F_COUNT, 2); tick();
    mem_resp_valid = 1; expect_f(F_COUNT, 1); tick();
    expect_f(F_COUNT, 0); expect_f(F_CYC, 8); expect_f(F_OVF, 1); tick();

    // Duplicates x3, x3, x4: stall holds until both x3 entries retire.
    set_ex(3, 0); set_id(OP_ADD, 3, 0); expect_f(F_STALL, 1); tick();
    set_ex(3, 0); set_id(OP_ADD, 3, 0); expect_f(F_STALL, 1); expect_f(F_COUNT, 1); tick();
    set_ex(4, 0); set_id(OP_ADD, 3, 0); expect_f(F_STALL, 1); expect_f(F_COUNT, 2); tick();
    set_id(OP_ADD, 3, 0); mem_resp_valid = 1; expect_f(F_STALL, 1); expect_f(F_COUNT, 3); tick();
    set_id(OP_ADD, 3, 0); mem_resp_valid = 1; expect_f(F_STALL, 1); expect_f(F_COUNT, 2); tick();
    set_id(OP_ADD, 3, 0); mem_resp_valid = 1; expect_f(F_STALL, 0); expect_f(F_COUNT, 1); tick();
    expect_f(F_COUNT, 0); expect_f(F_CYC, 13); tick();

    // Wrap-around: 10 alloc/pop pairs over a single resident entry.
    set_ex(9, 0); tick();
    for (int i = 0; i < 10; i++) begin
      set_ex(5'(10 + i), 0); mem_resp_valid = 1; expect_f(F_COUNT, 1); tick();
    end
    set_id(OP_ADD, 19, 0); mem_resp_valid = 1; expect_f(F_STALL, 1); expect_f(F_COUNT, 1); tick();
    expect_f(F_COUNT, 0); expect_f(F_CYC, 14); tick();

    // Flush kills the alloc; responses while empty flag underflow.
    set_ex(5, 1); set_id(OP_ADD, 5, 0); expect_f(F_STALL, 0); tick();
    set_id(OP_ADD, 5, 0); mem_resp_valid = 1; expect_f(F_STALL, 0); expect_f(F_COUNT, 0);
    expect_f(F_UNF, 0); tick();
    set_ex(12, 0); mem_resp_valid = 1; expect_f(F_UNF, 1); expect_f(F_COUNT, 0); tick();
    mem_resp_valid = 1; expect_f(F_COUNT, 1); tick();
    expect_f(F_COUNT, 0); tick();

    // cnt_clr under stall, then reset with two loads pending.
    set_ex(10, 0); tick();
    set_ex(11, 0); expect_f(F_COUNT, 1); tick();
    set_id(OP_ADD, 10, 0); expect_f(F_COUNT, 2); expect_f(F_STALL, 1); expect_f(F_CYC, 14); tick();
    set_id(OP_ADD, 10, 0); cnt_clr = 1; expect_f(F_STALL, 1); expect_f(F_CYC, 15); tick();
    set_id(OP_ADD, 10, 0); expect_f(F_CYC, 0); expect_f(F_STALL, 1); tick();
    rst_n = 0; set_id(OP_ADD, 10, 0); expect_f(F_STALL, 0); expect_f(F_CYC, 1); tick();
    rst_n = 1; set_id(OP_ADD, 10, 0); mem_resp_valid = 1;
    expect_f(F_STALL, 0); expect_f(F_COUNT, 0); expect_f(F_FULL, 0); expect_f(F_CYC, 0);
    expect_f(F_OVF, 0); expect_f(F_UNF, 0); tick();
    expect_f(F_UNF, 1); expect_f(F_COUNT, 0); tick();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL monitor_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
